// File: rtl/uart_rx_ctrl.sv
// Receive-side sequencing FSM for an oversampled UART.
// It detects the start bit, strobes the datapath checkers at the mid-bit check point and flags frame errors.
module uart_rx_ctrl #(
  parameter int PRESCALE   = 8,
  parameter int DATA_WIDTH = 8,
  localparam int EW = $clog2(PRESCALE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_in,
  input  logic          par_en,
  input  logic          strt_glitch,
  input  logic          par_err,
  input  logic          stp_err,
  output logic [EW-1:0] edge_cnt,
  output logic [3:0]    bit_cnt,
  output logic          dat_samp_en,
  output logic          deser_en,
  output logic          strt_chk_en,
  output logic          par_chk_en,
  output logic          stp_chk_en,
  output logic          data_valid,
  output logic          par_err_o,
  output logic          stp_err_o,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // The sampler votes on the three edges ending at CP_EDGE, so the
  // sampled bit is settled there.
  localparam logic [EW-1:0] CP_EDGE   = EW'(PRESCALE / 2 + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(PRESCALE - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_WIDTH);

  state_t state;
  logic   par_en_q;
  logic   at_cp;
  logic   at_wrap;

  assign at_cp     = (edge_cnt == CP_EDGE);
  assign at_wrap   = (edge_cnt == LAST_EDGE);
  assign state_dbg = state;

  always_comb begin
    dat_samp_en = (state != IDLE);
    strt_chk_en = (state == START)  && at_cp;
    deser_en    = (state == DATA)   && at_cp;
    par_chk_en  = (state == PARITY) && at_cp;
    stp_chk_en  = (state == STOP)   && at_cp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      par_en_q   <= 1'b0;
      data_valid <= 1'b0;
      par_err_o  <= 1'b0;
      stp_err_o  <= 1'b0;
    end else begin
      data_valid <= 1'b0;

      if (state == IDLE) begin
        edge_cnt <= '0;
        bit_cnt  <= '0;
      end else if (at_wrap) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + 4'd1;
      end else begin
        edge_cnt <= edge_cnt + EW'(1);
      end

      case (state)
        IDLE: begin
          if (!rx_in) begin
            state     <= START;
            par_en_q  <= par_en;
            par_err_o <= 1'b0;
            stp_err_o <= 1'b0;
          end
        end
        START: begin
          if (at_cp && strt_glitch) begin
            state    <= IDLE;
            edge_cnt <= '0;
            bit_cnt  <= '0;
          end else if (at_wrap) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (at_wrap && bit_cnt == LAST_DATA) begin
            state <= par_en_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (at_cp) par_err_o <= par_err;
          if (at_wrap) state <= STOP;
        end
        STOP: begin
          // Leave at the check point so a start bit right after the stop
          // bit is not missed.
          if (at_cp) begin
            stp_err_o  <= stp_err;
            data_valid <= !stp_err && !par_err_o;
            state      <= IDLE;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          edge_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl (PRESCALE=8, DATA_WIDTH=8).
// A bench-side shift register takes the line value on each deser_en strobe and stands in for the deserializer.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic       par_en;
  logic       strt_glitch;
  logic       par_err;
  logic       stp_err;
  logic [2:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en;
  logic       deser_en;
  logic       strt_chk_en;
  logic       par_chk_en;
  logic       stp_chk_en;
  logic       data_valid;
  logic       par_err_o;
  logic       stp_err_o;
  logic [2:0] state_dbg;

  uart_rx_ctrl #(.PRESCALE(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .par_en(par_en),
    .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en),
    .deser_en(deser_en), .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en),
    .stp_chk_en(stp_chk_en), .data_valid(data_valid), .par_err_o(par_err_o),
    .stp_err_o(stp_err_o), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int failed = 0;
  int t_start;
  int deser_cnt, deser_bad, par_chk_cnt, dv_cnt, dv_cyc, dv_prev;
  logic [7:0] shreg;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  // monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (deser_en) begin
      deser_cnt++;
      if (edge_cnt != 3'd5) deser_bad++;
      shreg = {rx_in, shreg[7:1]};
    end
    if (par_chk_en) par_chk_cnt++;
    if (data_valid) begin
      dv_cnt++;
      dv_prev = dv_cyc;
      dv_cyc  = cyc;
      got_q.push_back(shreg);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    deser_cnt = 0; deser_bad = 0; par_chk_cnt = 0; dv_cnt = 0;
    dv_cyc = 0; dv_prev = 0;
    got_q.delete();
  endtask

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe);
    par_en  = pe;
    t_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (pe) drive_bit(^d);
    drive_bit(1'b1);
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  task automatic check_frame_ok(input string tag, input logic [7:0] d);
    logic [7:0] e;
    logic [7:0] g;
    check({tag, "_dv_cnt"}, 32'(dv_cnt), 32'd1);
    check({tag, "_latency"}, 32'(dv_cyc - t_start), 32'd79);
    check({tag, "_deser_cnt"}, 32'(deser_cnt), 32'd8);
    check({tag, "_deser_edge"}, 32'(deser_bad), 32'd0);
    exp_q.push_back(d);
    if (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check({tag, "_data"}, 32'(g), 32'(e));
    end else begin
      check({tag, "_data_present"}, 32'(got_q.size()), 32'd1);
      exp_q.delete();
    end
    check({tag, "_par_err_o"}, 32'(par_err_o), 32'd0);
    check({tag, "_stp_err_o"}, 32'(stp_err_o), 32'd0);
  endtask

  initial begin
    rst = 1'b1; rx_in = 1'b1; par_en = 1'b0;
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    shreg = '0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_edge_cnt", 32'(edge_cnt), 32'd0);
    check("rst_bit_cnt", 32'(bit_cnt), 32'd0);
    check("rst_outputs", {26'd0, dat_samp_en, data_valid, par_err_o, stp_err_o, deser_en, stp_chk_en}, 32'd0);
    idle(3);

    // clean frame 0xB1, no parity
    clear_mon();
    send_frame(8'hB1, 1'b0);
    idle(4);
    check_frame_ok("f_b1", 8'hB1);

    // 0xC2 with parity, parity error reported
    clear_mon();
    par_err = 1'b1;
    send_frame(8'hC2, 1'b1);
    par_err = 1'b0;
    idle(4);
    check("c2_par_err_o", 32'(par_err_o), 32'd1);
    check("c2_dv_cnt", 32'(dv_cnt), 32'd0);
    check("c2_par_chk_cnt", 32'(par_chk_cnt), 32'd1);
    check("c2_deser_cnt", 32'(deser_cnt), 32'd8);
    check("c2_state_idle", 32'(state_dbg), 32'd0);

    // start glitch: short low pulse, start checker rejects it
    clear_mon();
    strt_glitch = 1'b1;
    t_start = cyc;
    rx_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx_in = 1'b1;
    check("gl_par_err_cleared", 32'(par_err_o), 32'd0);
    wait_cyc(t_start + 6);
    check("gl_start_at_cp", 32'({state_dbg, strt_chk_en}), 32'({3'd1, 1'b1}));
    wait_cyc(t_start + 7);
    check("gl_idle_c0p7", 32'(state_dbg), 32'd0);
    check("gl_counters", 32'({edge_cnt, bit_cnt}), 32'd0);
    strt_glitch = 1'b0;
    idle(20);
    check("gl_deser_cnt", 32'(deser_cnt), 32'd0);
    check("gl_flags_dv", 32'({par_err_o, stp_err_o, 1'b0}) + 32'(dv_cnt), 32'd0);

    // 0xD3 with stop error
    clear_mon();
    stp_err = 1'b1;
    send_frame(8'hD3, 1'b0);
    stp_err = 1'b0;
    idle(4);
    check("d3_stp_err_o", 32'(stp_err_o), 32'd1);
    check("d3_par_err_o", 32'(par_err_o), 32'd0);
    check("d3_dv_cnt", 32'(dv_cnt), 32'd0);

    // back-to-back 0xFF then 0xE4
    clear_mon();
    send_frame(8'hFF, 1'b0);
    send_frame(8'hE4, 1'b0);
    idle(4);
    check("b2b_dv_cnt", 32'(dv_cnt), 32'd2);
    check("b2b_spacing", 32'(dv_cyc - dv_prev), 32'd80);
    check("b2b_latency2", 32'(dv_cyc - t_start), 32'd79);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hE4);
    for (int i = 0; i < 2; i++) begin
      logic [7:0] e;
      logic [7:0] g;
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'h00;
      check($sformatf("b2b_data%0d", i), 32'(g), 32'(e));
    end
    check("b2b_stp_err_o", 32'(stp_err_o), 32'd0);

    // reset during data bit 4 aborts the frame
    clear_mon();
    par_en = 1'b0;
    t_start = cyc;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    rx_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rs_in_bit4", 32'({state_dbg, bit_cnt}), 32'({3'd2, 4'd4}));
    rst = 1'b1;
    rx_in = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rs_state_idle", 32'(state_dbg), 32'd0);
    check("rs_counters", 32'({edge_cnt, bit_cnt}), 32'd0);
    idle(90);
    check("rs_no_dv", 32'(dv_cnt), 32'd0);

    clear_mon();
    send_frame(8'hB1, 1'b0);
    idle(4);
    check_frame_ok("rs_b1", 8'hB1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Sequencing FSM for the UART receive datapath: oversampled start detection, per-bit sample/check timing, frame completion and error flags.
- Sits between the serial input and the RX datapath (majority-vote data sampler, deserializer, start/parity/stop checkers).
- Enables each datapath unit at the correct oversample edge and issues a single-cycle data_valid per good frame.

Parameters:
- PRESCALE, 8, clk cycles per serial bit (oversampling ratio); even, >= 4.
- DATA_WIDTH, 8, data bits per frame, sent LSB first.

Ports:
- clk  input  1  receiver clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_in  input  1  serial line; idle high.
- par_en  input  1  parity bit present; latched at start detection.
- strt_glitch  input  1  start checker result; valid in the strt_chk_en cycle.
- par_err  input  1  parity checker result; valid in the par_chk_en cycle.
- stp_err  input  1  stop checker result; valid in the stp_chk_en cycle.
- edge_cnt  output  $clog2(PRESCALE)  oversample index within the current bit.
- bit_cnt  output  4  bit index within the frame: start=0, data 1..DATA_WIDTH, parity, stop.
- dat_samp_en  output  1  enables the data sampler.
- deser_en  output  1  one-cycle shift strobe to the deserializer.
- strt_chk_en  output  1  one-cycle start-check strobe.
- par_chk_en  output  1  one-cycle parity-check strobe.
- stp_chk_en  output  1  one-cycle stop-check strobe.
- data_valid  output  1  one-cycle pulse: frame accepted.
- par_err_o  output  1  sticky parity-error flag for the last frame.
- stp_err_o  output  1  sticky stop-error flag for the last frame.

Behaviour:
- Reset: rst=1 at a clk edge forces state IDLE, edge_cnt=0, bit_cnt=0. All enables/strobes, data_valid, par_err_o and stp_err_o go to 0.
- Reset mid-frame aborts the frame; no data_valid follows.
- States: IDLE, START, DATA, PARITY, STOP.
- Counters: edge_cnt increments every cycle outside IDLE and wraps PRESCALE-1 -> 0. bit_cnt increments on each wrap. Both are held at 0 in IDLE.
- Check point: CP = edge_cnt == PRESCALE/2+1. The sampler votes on edges PRESCALE/2-1..PRESCALE/2+1, so sampled data is stable at CP.
- All strobes are combinational from state and counters: high only in the CP cycle of the matching state.
- dat_samp_en is high in every non-IDLE state.
- IDLE:
  - On rx_in==0: next state START with edge_cnt=0, bit_cnt=0; latch par_en; clear par_err_o and stp_err_o.
  - Otherwise remain in IDLE.
- START:
  - strt_chk_en at CP; if strt_glitch=1, go to IDLE next cycle (abort, no flags).
  - Otherwise, at edge_cnt==PRESCALE-1, go to DATA.
- DATA:
  - deser_en at CP of each data bit: exactly DATA_WIDTH pulses per frame.
  - After the wrap of the last data bit: go to PARITY if latched par_en=1, else to STOP.
- PARITY:
  - par_chk_en at CP; par_err_o <= par_err.
  - At the wrap, go to STOP.
- STOP:
  - stp_chk_en at CP; stp_err_o <= stp_err.
  - Next state IDLE at CP, not at end of bit, so the controller re-arms for back-to-back frames.
  - data_valid is registered: high in the cycle after the stop CP iff stp_err=0 and par_err_o=0.
- Latency (start detect cycle = c0):
  - par_en=0: data_valid at c0 + 1 + (DATA_WIDTH+1)*PRESCALE + PRESCALE/2 + 2.
  - par_en=1: add PRESCALE.
- par_en changes mid-frame are ignored.
- rx_in is not examined outside IDLE; the checkers' results are the only line validation.

Test Plan:
- Frame 0xB1, par_en=0, PRESCALE=8, all error inputs 0 -> deser_en pulses 8 times at edge_cnt=5; single data_valid at c0+79; flags 0.
- Frame 0xC2, par_en=1, par_err=1 driven at the par_chk_en cycle -> par_err_o=1; no data_valid; returns to IDLE; flag clears on next start.
- rx_in low for 2 cycles, strt_glitch=1 at strt_chk_en -> back to IDLE at c0+7; zero deser_en pulses; no flags.
- Frame 0xD3, stp_err=1 at stp_chk_en -> stp_err_o=1, no data_valid.
- Back-to-back frames 0xFF then 0xE4 with no idle gap -> two data_valid pulses exactly 80 cycles apart (par_en=0); second start detected.
- rst=1 for one cycle during DATA bit 4 -> next cycle IDLE, counters 0; no data_valid; next clean frame 0xB1 is accepted normally.
